// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
// Groups the instruction-fetch unit's control and memory signals into one
// bundle.
//
// Control side (Control / datapath -> fetch unit):
//   fetch        request to fetch the next instruction
//   pc_load      redirect strobe (branch taken)
//   pc_in        64-bit redirect target
// Memory side:
//   mem_addr     64-bit instruction memory address (fetch unit -> memory)
//   mem_rd       read request (fetch unit -> memory)
//   mem_data     32-bit read data (memory -> fetch unit)
//   mem_ready    read data valid (memory -> fetch unit)
// Results (fetch unit -> Control):
//   instr        held instruction word
//   instr_valid  one-cycle pulse when a new word lands in instr
//   pc           address of the word currently held in instr
//   busy         a memory request is outstanding
//   fault        sticky fetch fault
//
// Modports:
//   master  the environment around the fetch unit (Control plus memory)
//   slave   the fetch unit itself
// ---------------------------------------------------------------------------
interface instr_fetch_if;
   logic        fetch;
   logic        pc_load;
   logic [63:0] pc_in;
   logic [63:0] mem_addr;
   logic        mem_rd;
   logic [31:0] mem_data;
   logic        mem_ready;
   logic [31:0] instr;
   logic        instr_valid;
   logic [63:0] pc;
   logic        busy;
   logic        fault;

   modport master (
      output fetch, pc_load, pc_in, mem_data, mem_ready,
      input  mem_addr, mem_rd, instr, instr_valid, pc, busy, fault
   );

   modport slave (
      input  fetch, pc_load, pc_in, mem_data, mem_ready,
      output mem_addr, mem_rd, instr, instr_valid, pc, busy, fault
   );
endinterface

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Instruction fetch unit. On a fetch request it issues a single read to
// instruction memory at the next-fetch address (or at the redirect target
// when a redirect arrives in the same cycle), waits for mem_ready, and then
// holds the returned word and its address for Control. A redirect that
// arrives while a read is outstanding discards that read's data. Misaligned
// targets and memory timeouts park the unit in a sticky fault state, which
// only reset can clear.
//
// Parameters:
//   RESET_PC     PC value loaded by reset
//   MEM_TIMEOUT  WAIT cycles without mem_ready before a fault (1..255)
//
// Ports:
//   clk   sole clock, rising edge
//   rst   synchronous, active-low reset
//   bus   instr_fetch_if.slave (fetch/pc_load/pc_in in, memory handshake,
//         instr/instr_valid/pc/busy/fault out)
// ---------------------------------------------------------------------------
module instr_fetch #(
   parameter logic [63:0] RESET_PC    = 64'h0,
   parameter int          MEM_TIMEOUT = 16
) (
   input logic          clk,
   input logic          rst,
   instr_fetch_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      FAULT
   } state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

   state_t      state_q, state_d;
   logic [63:0] npc_q, npc_d;
   logic [63:0] addr_q, addr_d;
   logic [63:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic        redir_q, redir_d;
   logic [7:0]  cnt_q, cnt_d;

   logic [63:0] fetchTarget;
   logic [7:0]  cntInc;

   // State register. Reset is synchronous and overrides every other input
   // on the same edge, which also aborts any read still outstanding.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         npc_q   <= RESET_PC;
         addr_q  <= RESET_PC;
         pc_q    <= RESET_PC;
         instr_q <= 32'h0;
         valid_q <= 1'b0;
         redir_q <= 1'b0;
         cnt_q   <= 8'h0;
      end else begin
         state_q <= state_d;
         npc_q   <= npc_d;
         addr_q  <= addr_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         redir_q <= redir_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic. A redirect in the same cycle as a fetch takes
   // effect immediately. A redirect seen during WAIT, whether before or
   // together with mem_ready, turns the in-flight read into a discard.
   // In that case npc keeps the redirect target rather than being bumped
   // by 4.
   always_comb begin
      state_d     = state_q;
      npc_d       = npc_q;
      addr_d      = addr_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      valid_d     = 1'b0;
      redir_d     = redir_q;
      cnt_d       = cnt_q;
      cntInc      = cnt_q + 8'd1;
      fetchTarget = bus.pc_load ? bus.pc_in : npc_q;

      unique case (state_q)
         IDLE: begin
            if (bus.fetch) begin
               if (fetchTarget[1:0] != 2'b00) begin
                  state_d = FAULT;
               end else begin
                  addr_d  = fetchTarget;
                  cnt_d   = 8'h0;
                  redir_d = 1'b0;
                  state_d = WAIT;
               end
            end else if (bus.pc_load) begin
               npc_d = bus.pc_in;
            end
         end
         WAIT: begin
            if (bus.pc_load) begin
               npc_d = bus.pc_in;
            end
            if (bus.mem_ready) begin
               if (!(redir_q || bus.pc_load)) begin
                  instr_d = bus.mem_data;
                  pc_d    = addr_q;
                  npc_d   = addr_q + 64'd4;
                  valid_d = 1'b1;
               end
               redir_d = 1'b0;
               state_d = IDLE;
            end else begin
               redir_d = redir_q | bus.pc_load;
               cnt_d   = cntInc;
               if (cntInc == TIMEOUT_CNT) begin
                  state_d = FAULT;
               end
            end
         end
         FAULT: begin
            state_d = FAULT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are decoded directly from registered state, so they are
   // glitch-free and change only on the clock edge.
   assign bus.mem_addr    = addr_q;
   assign bus.mem_rd      = (state_q == WAIT);
   assign bus.busy        = (state_q == WAIT);
   assign bus.fault       = (state_q == FAULT);
   assign bus.instr       = instr_q;
   assign bus.instr_valid = valid_q;
   assign bus.pc          = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch (MEM_TIMEOUT = 4, RESET_PC = 0).
// Phase 1 applies a table of hand-computed vectors. Phase 2 runs the
// misalign-fault and timeout sequences. Phase 3 drives random traffic
// against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

   localparam int          TIMEOUT = 4;
   localparam logic [63:0] RST_PC  = 64'h0;
   localparam int          NRAND   = 3000;

   logic clk;
   logic rst;

   instr_fetch_if ifc ();

   instr_fetch #(
      .RESET_PC    (RST_PC),
      .MEM_TIMEOUT (TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   // Free-running 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [63:0] addr;
      logic        rd;
      logic [31:0] instr;
      logic        valid;
      logic [63:0] pc;
      logic        busy;
      logic        fault;
   } exp_t;

   typedef struct {
      logic        rstn;
      logic        fetch;
      logic        pcLoad;
      logic [63:0] pcIn;
      logic        ready;
      logic [31:0] data;
      exp_t        e;
   } vec_t;

   int checks   = 0;
   int failures = 0;

   vec_t vecs[$];

   // Reference model state: transaction view of the fetch unit
   bit              mFaulted;
   bit              mPending;
   bit              mRedirect;
   int              mWaited;
   longint unsigned mNpc;
   longint unsigned mReqAddr;
   longint unsigned mPc;
   logic [31:0]     mInstr;
   bit              mValid;

   function automatic exp_t mkExp(logic [63:0] addr, logic rd, logic [31:0] instr,
                                  logic valid, logic [63:0] pc, logic fault);
      exp_t e;
      e.addr  = addr;
      e.rd    = rd;
      e.instr = instr;
      e.valid = valid;
      e.pc    = pc;
      e.busy  = rd;
      e.fault = fault;
      return e;
   endfunction

   function automatic vec_t mkVec(logic rstn, logic fetch, logic pcLoad, logic [63:0] pcIn,
                                  logic ready, logic [31:0] data, exp_t e);
      vec_t v;
      v.rstn   = rstn;
      v.fetch  = fetch;
      v.pcLoad = pcLoad;
      v.pcIn   = pcIn;
      v.ready  = ready;
      v.data   = data;
      v.e      = e;
      return v;
   endfunction

   // Drive one cycle of inputs from a negedge; return at the following negedge
   task automatic applyStimulus(logic rstn, logic fetch, logic pcLoad, logic [63:0] pcIn,
                                logic ready, logic [31:0] data);
      rst           = rstn;
      ifc.fetch     = fetch;
      ifc.pc_load   = pcLoad;
      ifc.pc_in     = pcIn;
      ifc.mem_ready = ready;
      ifc.mem_data  = data;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkField(string tag, string field, logic [63:0] got, logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("[TB] FAIL %s.%s got=%h want=%h", tag, field, got, want);
      end
   endtask

   task automatic checkOutput(string tag, exp_t e);
      checkField(tag, "mem_addr",    ifc.mem_addr,           e.addr);
      checkField(tag, "mem_rd",      64'(ifc.mem_rd),        64'(e.rd));
      checkField(tag, "instr",       64'(ifc.instr),         64'(e.instr));
      checkField(tag, "instr_valid", 64'(ifc.instr_valid),   64'(e.valid));
      checkField(tag, "pc",          ifc.pc,                 e.pc);
      checkField(tag, "busy",        64'(ifc.busy),          64'(e.busy));
      checkField(tag, "fault",       64'(ifc.fault),         64'(e.fault));
   endtask

   task automatic modelReset();
      mFaulted  = 0;
      mPending  = 0;
      mRedirect = 0;
      mWaited   = 0;
      mNpc      = RST_PC;
      mReqAddr  = RST_PC;
      mPc       = RST_PC;
      mInstr    = 32'h0;
      mValid    = 0;
   endtask

   // Advance the model by one clock edge given the inputs seen at that edge
   task automatic modelStep(logic rstn, logic fetch, logic pcLoad, logic [63:0] pcIn,
                            logic ready, logic [31:0] data);
      longint unsigned target;
      if (!rstn) begin
         modelReset();
         return;
      end
      mValid = 0;
      if (mFaulted) return;
      if (mPending) begin
         if (pcLoad) begin
            mRedirect = 1;
            mNpc      = pcIn;
         end
         if (ready) begin
            if (!mRedirect) begin
               mInstr = data;
               mPc    = mReqAddr;
               mNpc   = mReqAddr + 64'd4;
               mValid = 1;
            end
            mPending  = 0;
            mRedirect = 0;
         end else begin
            mWaited++;
            if (mWaited >= TIMEOUT) begin
               mFaulted = 1;
               mPending = 0;
            end
         end
      end else if (fetch) begin
         target = pcLoad ? pcIn : mNpc;
         if (target % 4 != 0) begin
            mFaulted = 1;
         end else begin
            mPending  = 1;
            mRedirect = 0;
            mReqAddr  = target;
            mWaited   = 0;
         end
      end else if (pcLoad) begin
         mNpc = pcIn;
      end
   endtask

   function automatic exp_t modelExp();
      return mkExp(mReqAddr, mPending, mInstr, mValid, mPc, mFaulted);
   endfunction

   // Main test sequence
   initial begin
      logic        rFetch, rLoad, rReady, rRstn;
      logic [63:0] rPcIn;
      logic [31:0] rData;
      exp_t        resetExp;

      rst           = 1'b0;
      ifc.fetch     = 1'b0;
      ifc.pc_load   = 1'b0;
      ifc.pc_in     = 64'h0;
      ifc.mem_ready = 1'b0;
      ifc.mem_data  = 32'h0;
      @(negedge clk);

      resetExp = mkExp(64'h0, 0, 32'h0, 0, 64'h0, 0);

      // ---- Phase 1: table of vectors ----
      vecs.push_back(mkVec(0, 0, 0, 0,      0, 0,            resetExp));
      vecs.push_back(mkVec(1, 1, 0, 0,      0, 0,            mkExp(64'h0,   1, 32'h0,        0, 64'h0,   0)));
      vecs.push_back(mkVec(1, 0, 0, 0,      1, 32'hD28000A2, mkExp(64'h0,   0, 32'hD28000A2, 1, 64'h0,   0)));
      vecs.push_back(mkVec(1, 0, 0, 0,      0, 0,            mkExp(64'h0,   0, 32'hD28000A2, 0, 64'h0,   0)));
      vecs.push_back(mkVec(1, 1, 0, 0,      0, 0,            mkExp(64'h4,   1, 32'hD28000A2, 0, 64'h0,   0)));
      vecs.push_back(mkVec(1, 0, 0, 0,      0, 0,            mkExp(64'h4,   1, 32'hD28000A2, 0, 64'h0,   0)));
      vecs.push_back(mkVec(1, 1, 0, 0,      0, 0,            mkExp(64'h4,   1, 32'hD28000A2, 0, 64'h0,   0)));
      vecs.push_back(mkVec(1, 0, 0, 0,      0, 0,            mkExp(64'h4,   1, 32'hD28000A2, 0, 64'h0,   0)));
      vecs.push_back(mkVec(1, 0, 0, 0,      1, 32'h91000843, mkExp(64'h4,   0, 32'h91000843, 1, 64'h4,   0)));
      vecs.push_back(mkVec(1, 0, 0, 0,      0, 0,            mkExp(64'h4,   0, 32'h91000843, 0, 64'h4,   0)));
      vecs.push_back(mkVec(1, 1, 0, 0,      0, 0,            mkExp(64'h8,   1, 32'h91000843, 0, 64'h4,   0)));
      vecs.push_back(mkVec(1, 0, 1, 64'h100, 0, 0,           mkExp(64'h8,   1, 32'h91000843, 0, 64'h4,   0)));
      vecs.push_back(mkVec(1, 0, 0, 0,      1, 32'hDEADBEEF, mkExp(64'h8,   0, 32'h91000843, 0, 64'h4,   0)));
      vecs.push_back(mkVec(1, 1, 0, 0,      0, 0,            mkExp(64'h100, 1, 32'h91000843, 0, 64'h4,   0)));
      vecs.push_back(mkVec(1, 0, 0, 0,      1, 32'h11111111, mkExp(64'h100, 0, 32'h11111111, 1, 64'h100, 0)));
      vecs.push_back(mkVec(1, 1, 0, 0,      0, 0,            mkExp(64'h104, 1, 32'h11111111, 0, 64'h100, 0)));
      vecs.push_back(mkVec(1, 0, 1, 64'h200, 1, 32'h22222222, mkExp(64'h104, 0, 32'h11111111, 0, 64'h100, 0)));
      vecs.push_back(mkVec(1, 1, 0, 0,      0, 0,            mkExp(64'h200, 1, 32'h11111111, 0, 64'h100, 0)));
      vecs.push_back(mkVec(1, 0, 0, 0,      1, 32'h33333333, mkExp(64'h200, 0, 32'h33333333, 1, 64'h200, 0)));
      vecs.push_back(mkVec(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0,
                           mkExp(64'h200, 0, 32'h33333333, 0, 64'h200, 0)));
      vecs.push_back(mkVec(1, 1, 0, 0,      0, 0,
                           mkExp(64'hFFFF_FFFF_FFFF_FFFC, 1, 32'h33333333, 0, 64'h200, 0)));
      vecs.push_back(mkVec(1, 0, 0, 0,      1, 32'h44444444,
                           mkExp(64'hFFFF_FFFF_FFFF_FFFC, 0, 32'h44444444, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0)));
      vecs.push_back(mkVec(1, 1, 0, 0,      0, 0,
                           mkExp(64'h0, 1, 32'h44444444, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0)));
      vecs.push_back(mkVec(1, 0, 0, 0,      1, 32'h55555555, mkExp(64'h0,   0, 32'h55555555, 1, 64'h0,   0)));
      vecs.push_back(mkVec(1, 0, 0, 0,      1, 32'h66666666, mkExp(64'h0,   0, 32'h55555555, 0, 64'h0,   0)));
      vecs.push_back(mkVec(1, 1, 0, 0,      0, 0,            mkExp(64'h4,   1, 32'h55555555, 0, 64'h0,   0)));
      vecs.push_back(mkVec(0, 1, 1, 64'h40, 1, 32'h77777777, resetExp));
      vecs.push_back(mkVec(1, 0, 0, 0,      1, 32'h88888888, resetExp));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rstn, vecs[i].fetch, vecs[i].pcLoad, vecs[i].pcIn,
                       vecs[i].ready, vecs[i].data);
         checkOutput($sformatf("vec%0d", i), vecs[i].e);
      end

      // ---- Phase 2a: misaligned redirect with fetch goes straight to FAULT ----
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("mis_reset", resetExp);
      applyStimulus(1, 1, 1, 64'h102, 0, 0);
      checkOutput("mis_enter", mkExp(64'h0, 0, 32'h0, 0, 64'h0, 1));
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 1, (i % 2 == 0), 64'h300, 1, 32'hCAFEF00D);
         checkOutput($sformatf("mis_hold%0d", i), mkExp(64'h0, 0, 32'h0, 0, 64'h0, 1));
      end
      applyStimulus(0, 1, 0, 0, 0, 0);
      checkOutput("mis_exit", resetExp);

      // ---- Phase 2b: timeout after four WAIT cycles, then reset recovery ----
      applyStimulus(1, 1, 0, 0, 0, 0);
      checkOutput("to_wait0", mkExp(64'h0, 1, 32'h0, 0, 64'h0, 0));
      for (int i = 1; i < TIMEOUT; i++) begin
         applyStimulus(1, 0, 0, 0, 0, 0);
         checkOutput($sformatf("to_wait%0d", i), mkExp(64'h0, 1, 32'h0, 0, 64'h0, 0));
      end
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("to_fault", mkExp(64'h0, 0, 32'h0, 0, 64'h0, 1));
      applyStimulus(1, 1, 0, 0, 1, 32'h12345678);
      checkOutput("to_stuck", mkExp(64'h0, 0, 32'h0, 0, 64'h0, 1));
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("to_reset", resetExp);

      // ---- Phase 3: random traffic against the reference model ----
      applyStimulus(0, 0, 0, 0, 0, 0);
      modelReset();
      checkOutput("rnd_start", modelExp());
      for (int n = 0; n < NRAND; n++) begin
         rRstn  = ($urandom_range(0, 39) != 0);
         rFetch = $urandom_range(0, 1);
         rLoad  = ($urandom_range(0, 7) == 0);
         rReady = ($urandom_range(0, 9) < 4);
         rData  = $urandom;
         case ($urandom_range(0, 7))
            0:       rPcIn = {$urandom, $urandom} | 64'h1;
            1:       rPcIn = 64'hFFFF_FFFF_FFFF_FFF8 | 64'(4 * $urandom_range(0, 1));
            default: rPcIn = {$urandom, $urandom} & ~64'h3;
         endcase
         modelStep(rRstn, rFetch, rLoad, rPcIn, rReady, rData);
         applyStimulus(rRstn, rFetch, rLoad, rPcIn, rReady, rData);
         checkOutput($sformatf("rnd%0d", n), modelExp());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, 64'h0, PC value loaded by reset.
REQ-002 Parameter MEM_TIMEOUT, 16, max WAIT cycles before fault; legal range 1..255.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 fetch  input  1  request from Control to fetch next instruction.
REQ-006 pc_load  input  1  redirect strobe from datapath (branch taken).
REQ-007 pc_in  input  64  redirect target.
REQ-008 mem_addr  output  64  instruction memory address.
REQ-009 mem_rd  output  1  instruction memory read request.
REQ-010 mem_data  input  32  instruction memory read data.
REQ-011 mem_ready  input  1  memory data valid; qualifies mem_data.
REQ-012 instr  output  32  held instruction word, drives Control instruction input.
REQ-013 instr_valid  output  1  one-cycle pulse: new word in instr.
REQ-014 pc  output  64  address of word currently in instr.
REQ-015 busy  output  1  high in WAIT.
REQ-016 fault  output  1  sticky fetch fault (misalign or timeout).

Function
REQ-017 Internal next-fetch register npc; FSM states IDLE, WAIT, FAULT; wait counter 8 bits.
REQ-018 IDLE: mem_rd=0; on fetch=1: if target[1:0]!=0 go FAULT, else latch target into mem_addr, clear counter, go WAIT; target is pc_in if pc_load=1 same cycle, else npc.
REQ-019 IDLE with pc_load=1 and fetch=0: npc<=pc_in; stay IDLE.
REQ-020 WAIT: mem_rd=1, busy=1, mem_addr held stable for whole WAIT.
REQ-021 WAIT and mem_ready=1 at edge, no redirect pending: instr<=mem_data, pc<=mem_addr, npc<=mem_addr+4, instr_valid=1 next cycle only, go IDLE.
REQ-022 npc+4 arithmetic 64-bit unsigned, wraps modulo 2^64 (FFFF_FFFF_FFFF_FFFC -> 0).
REQ-023 pc_load=1 in WAIT: set redirect-pending flag, npc<=pc_in; on completion word discarded, instr/pc unchanged, instr_valid stays 0, npc not incremented, go IDLE, flag cleared.
REQ-024 pc_load and mem_ready both high in same WAIT cycle: redirect wins, word discarded per REQ-023.
REQ-025 fetch=1 while in WAIT or FAULT ignored; not queued.
REQ-026 WAIT counter increments each WAIT cycle with mem_ready=0; reaching MEM_TIMEOUT goes FAULT, mem_rd drops next cycle.
REQ-027 FAULT: fault=1, mem_rd=0, busy=0, instr_valid=0, instr/pc frozen; exits only via reset; pc_load ignored.
REQ-028 Minimum latency fetch-to-instr_valid: 2 cycles (fetch edge k, mem_ready at k+1, instr_valid high during cycle k+2).
REQ-029 mem_data sampled only when state=WAIT and mem_ready=1; mem_ready outside WAIT ignored.

Reset
REQ-030 rst=0 at an edge: state IDLE, npc=RESET_PC, pc=RESET_PC, mem_addr=RESET_PC, instr=32'h0, instr_valid=0, mem_rd=0, busy=0, fault=0, counter=0, redirect flag=0.
REQ-031 Reset mid-WAIT aborts request; mem_rd=0 from the cycle after the reset edge; any late mem_ready ignored.
REQ-032 Reset has priority over all other inputs on the same edge.

Verification
REQ-033 Reset, fetch=1 one cycle, mem_ready=1 next cycle with mem_data=32'hD28000A2 -> mem_addr=0, instr=32'hD28000A2, pc=0, instr_valid one-cycle pulse 2 cycles after fetch, npc=4.
REQ-034 Second fetch, memory delays 3 cycles, mem_data=32'h91000843 -> busy/mem_rd high 4 cycles, mem_addr=4, instr=32'h91000843, pc=4, one instr_valid pulse.
REQ-035 pc_load=1 pc_in=64'h100 during WAIT, then mem_ready -> no instr_valid, instr unchanged; next fetch issues mem_addr=64'h100.
REQ-036 pc_load=1 pc_in=64'h102 with fetch=1 in IDLE -> FAULT next cycle, fault=1, mem_rd never asserted; further fetch ignored until rst=0.
REQ-037 MEM_TIMEOUT=4, fetch, mem_ready held 0 -> fault=1 after 4 WAIT cycles, mem_rd deasserted; rst=0 restores REQ-030 values.
REQ-038 npc=64'hFFFF_FFFF_FFFF_FFFC via pc_load, fetch, mem_ready -> pc=64'hFFFF_FFFF_FFFF_FFFC, next fetch mem_addr=0.
